// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serial transmitter.
// Defining PISO_PARITY_EN adds one parity bit to every frame.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/bit_counter.sv
// Up-counter with async active-high clear, sync clear and count enable.
// Sync clear takes priority over enable.
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sclr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/piso_shift_tx.sv
// WIDTH-bit parallel-in, MSB-first serial-out transmitter with valid and done pulse.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             DONE
);

  localparam int FRAME = WIDTH + PARITY_BITS;
  localparam int CW    = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(FRAME);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sout_q, sout_d;
  logic             svalid_q, svalid_d;
  logic             done_q, done_d;
  logic             cnt_en, cnt_clr;
  logic [CW-1:0]    cnt;
  logic             next_bit;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;

  assign par_d    = (state_q == IDLE && LOAD) ? ^DIN : par_q;
  // Once the last data bit is on the line, the next bit out is the parity.
  assign next_bit = (cnt == CW'(WIDTH)) ? par_q : sr_q[WIDTH-1];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign next_bit = sr_q[WIDTH-1];
`endif

  bit_counter #(.W(CW)) u_cnt (
    .clk_i (CLK),
    .rst_i (CLR),
    .sclr_i(cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    sout_d   = 1'b0;
    svalid_d = 1'b0;
    done_d   = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          sout_d   = DIN[WIDTH-1];
          sr_d     = DIN << 1;
          svalid_d = 1'b1;
          cnt_en   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          done_d  = 1'b1;
          cnt_clr = 1'b1;
          state_d = FINISH;
        end else begin
          sout_d   = next_bit;
          sr_d     = sr_q << 1;
          svalid_d = 1'b1;
          cnt_en   = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
    end
  end

  assign READY  = (state_q == IDLE);
  assign SOUT   = sout_q;
  assign SVALID = svalid_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx (WIDTH=8): frame-level model plus directed words.
module tb_piso_shift_tx;
  import piso_pkg::*;

  localparam int W  = 8;
  localparam int FR = W + PARITY_BITS;

  logic         CLK = 1'b0;
  logic         CLR = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         READY, SOUT, SVALID, DONE;

  int n_chk  = 0;
  int n_fail = 0;
  bit clk_run = 1'b0;
  bit chk_on  = 1'b0;

  piso_shift_tx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .LOAD  (LOAD),
    .DIN   (DIN),
    .READY (READY),
    .SOUT  (SOUT),
    .SVALID(SVALID),
    .DONE  (DONE)
  );

  initial forever begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame as it should appear on the wire: data MSB first, then parity if built in.
  function automatic logic [31:0] frame_of(input logic [7:0] w);
    if (PARITY_BITS != 0) return {23'b0, w, ^w};
    return {24'b0, w};
  endfunction

  // Model: an accepted word becomes a list of per-cycle expected outputs.
  typedef struct packed {
    logic sout;
    logic svalid;
    logic done;
    logic ready;
  } obs_t;

  localparam obs_t IDLE_OBS = 4'b0001;

  obs_t exp_q[$];
  obs_t exp_o  = IDLE_OBS;
  bit   m_ready = 1'b1;

  always @(posedge CLK) begin
    if (CLR) begin
      exp_q.delete();
      exp_o   = IDLE_OBS;
      m_ready = 1'b1;
    end else begin
      if (m_ready && LOAD) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({DIN[i], 1'b1, 1'b0, 1'b0});
        if (PARITY_BITS != 0) exp_q.push_back({^DIN, 1'b1, 1'b0, 1'b0});
        exp_q.push_back(4'b0010);
      end
      if (exp_q.size() > 0) exp_o = exp_q.pop_front();
      else exp_o = IDLE_OBS;
      m_ready = exp_o.ready;
    end
  end

  always @(posedge CLR) begin
    exp_q.delete();
    exp_o   = IDLE_OBS;
    m_ready = 1'b1;
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      check("cyc_ready",  {31'b0, READY},  {31'b0, exp_o.ready});
      check("cyc_svalid", {31'b0, SVALID}, {31'b0, exp_o.svalid});
      check("cyc_sout",   {31'b0, SOUT},   {31'b0, exp_o.sout});
      check("cyc_done",   {31'b0, DONE},   {31'b0, exp_o.done});
    end
  end

  // Receiver: collects valid bits into words, closed by DONE.
  logic [31:0] rx_bits = '0;
  int          rx_len  = 0;
  logic [31:0] rx_word[$];
  int          rx_n[$];

  always @(negedge CLK) begin
    if (CLR) begin
      rx_bits = '0;
      rx_len  = 0;
    end else begin
      if (SVALID) begin
        rx_bits = {rx_bits[30:0], SOUT};
        rx_len++;
      end
      if (DONE) begin
        rx_word.push_back(rx_bits);
        rx_n.push_back(rx_len);
        rx_bits = '0;
        rx_len  = 0;
      end
    end
  end

  task automatic drive(input logic l, input logic [W-1:0] d);
    @(negedge CLK);
    #1;
    LOAD = l;
    DIN  = d;
  endtask

  task automatic load_one(input logic [W-1:0] d);
    drive(1'b1, d);
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (DONE !== 1'b1 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check(nm, {31'b0, (k < 40)}, 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int cyc;
    int low_cnt;
    int rise_cyc;
    logic prev_v;

    // Async clear with the clock stopped.
    #3 CLR = 1'b1;
    #1;
    check("rst_ready",  {31'b0, READY},  32'd1);
    check("rst_sout",   {31'b0, SOUT},   32'd0);
    check("rst_svalid", {31'b0, SVALID}, 32'd0);
    check("rst_done",   {31'b0, DONE},   32'd0);
    #5 CLR = 1'b0;
    clk_run = 1'b1;
    chk_on  = 1'b1;
    repeat (2) @(negedge CLK);

    // Single word, timing pinned: DONE on cycle FR+1, READY on FR+2.
    drive(1'b1, 8'hA5);
    @(posedge CLK);
    #1 LOAD = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (DONE !== 1'b1 && cyc < 30);
    check("a5_done_cycle", cyc, FR + 1);
    @(negedge CLK);
    check("a5_ready_cycle", {31'b0, READY}, 32'd1);
    repeat (2) @(negedge CLK);

    // LOAD while busy must be ignored.
    load_one(8'h3C);
    repeat (3) @(negedge CLK);
    #1;
    LOAD = 1'b1;
    DIN  = 8'hFF;
    repeat (2) @(negedge CLK);
    #1 LOAD = 1'b0;
    wait_done("3c_timeout");

    // LOAD held high across two frames.
    drive(1'b1, 8'h81);
    @(posedge CLK);
    #1 DIN = 8'h7E;
    cyc      = 0;
    low_cnt  = 0;
    rise_cyc = 0;
    prev_v   = 1'b1;
    while (cyc < 2 * FR + 2) begin
      @(negedge CLK);
      cyc++;
      if (SVALID === 1'b0) low_cnt++;
      if (SVALID === 1'b1 && prev_v === 1'b0 && rise_cyc == 0) rise_cyc = cyc;
      prev_v = SVALID;
      if (cyc == FR + 3) begin
        #1 LOAD = 1'b0;
      end
    end
    check("held_gap_low_cycles", low_cnt, 2);
    check("held_second_start", rise_cyc, FR + 3);
    wait_done("7e_timeout");

    // Clear in the middle of a word.
    load_one(8'hC3);
    repeat (3) @(negedge CLK);
    #2 CLR = 1'b1;
    #1;
    check("abort_svalid", {31'b0, SVALID}, 32'd0);
    check("abort_ready",  {31'b0, READY},  32'd1);
    check("abort_done",   {31'b0, DONE},   32'd0);
    check("abort_sout",   {31'b0, SOUT},   32'd0);
    @(negedge CLK);
    #1 CLR = 1'b0;
    check("abort_no_frame", rx_word.size(), 4);
    repeat (2) @(negedge CLK);
    load_one(8'h01);
    wait_done("01_timeout");

    // Received frames against hand-picked words.
    check("frame_count", rx_word.size(), 5);
    check("frame0_a5", rx_word[0], frame_of(8'hA5));
    check("frame1_3c", rx_word[1], frame_of(8'h3C));
    check("frame2_81", rx_word[2], frame_of(8'h81));
    check("frame3_7e", rx_word[3], frame_of(8'h7E));
    check("frame4_01", rx_word[4], frame_of(8'h01));
    check("frame0_len", rx_n[0], FR);
    check("frame4_len", rx_n[4], FR);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in serial-out shift transmitter.
- Accepts a WIDTH-bit word on a LOAD strobe and shifts it out MSB-first, one bit per CLK, with a valid qualifier and an end-of-word pulse.
- Serves as the transmit end of the lab's serial link; its stream feeds the serial-in parallel-out receiver.
- Built from state register, shift register and bit counter flops with async clear.

Parameters:
- WIDTH, 8, data word width in bits (legal range 1 to 32).

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous active-high reset.
- LOAD  input  1  load strobe; sampled on rising CLK only while READY=1.
- DIN  input  WIDTH  parallel word captured on an accepted LOAD.
- READY  output  1  high in IDLE; word may be loaded.
- SOUT  output  1  serial data, registered.
- SVALID  output  1  high while SOUT carries a valid bit, registered.
- DONE  output  1  one-cycle pulse after the last bit, registered.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (CLR). Any CLR assertion forces all state immediately, independent of CLK.
- Reset values: state=IDLE, shift register=0, bit counter=0, SOUT=0, SVALID=0, DONE=0. READY=1, because it is decoded from state==IDLE.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - READY=1, SVALID=0, SOUT=0.
  - On a rising edge with LOAD=1: capture DIN, drive SOUT=DIN[WIDTH-1], set SVALID=1, counter=1, go to SHIFT.
  - LOAD=0 keeps the block in IDLE.
- SHIFT:
  - READY=0.
  - Each edge shifts the register left and drives the next lower bit on SOUT; the counter increments.
  - When counter==WIDTH, the next edge clears SVALID and SOUT, pulses DONE=1 and goes to FINISH.
  - Result: SVALID is high for exactly WIDTH consecutive cycles.
- FINISH:
  - DONE=1 for this single cycle; READY=0.
  - Next edge returns to IDLE with DONE=0.
- Latency: the first bit appears one cycle after the LOAD edge. The minimum word-to-word period is WIDTH+2 cycles.
- LOAD while busy (SHIFT or FINISH) is ignored. DIN is not re-sampled and the word in flight is unaffected.
- LOAD held high continuously: a new word is accepted on the first IDLE edge, then the sequence repeats.
- CLR mid-word: the transfer aborts at once and outputs go to reset values. No DONE pulse is issued for the aborted word.
- CLR deasserted: the first edge with LOAD=1 starts a fresh word.
- WIDTH=1: SVALID is high for one cycle, then FINISH.
- The counter is $clog2(WIDTH+2) bits wide. It must not wrap before WIDTH+1 is representable.
- The shift register fills with 0 from the LSB side.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - After the WIDTH data bits, SHIFT emits one extra bit equal to the even parity (XOR) of the captured word.
  - SVALID is high for WIDTH+1 cycles, and the minimum word period becomes WIDTH+3 cycles.
  - DONE follows the parity bit.
  - Parity is computed at capture and held in a dedicated flop.
- When undefined: no parity flop, no extra bit; timing exactly as above.

Decomposition:
- Shared package piso_pkg:
  - state typedef (IDLE=2'b00, SHIFT=2'b01, FINISH=2'b10);
  - default WIDTH constant;
  - PARITY_BITS constant (1 when PISO_PARITY_EN is defined, else 0), used to derive the frame length WIDTH+PARITY_BITS.
- One sub-module, bit_counter: up-counter with async active-high clear, synchronous clear and enable.
- FSM and shift register stay in piso_shift_tx.

Test Plan (WIDTH=8):
- Reset: CLR pulsed mid-cycle with CLK stopped -> READY=1, SOUT=0, SVALID=0, DONE=0 immediately.
- LOAD=1 with DIN=8'hA5 for one edge -> SOUT sequence 1,0,1,0,0,1,0,1 on the next 8 cycles with SVALID=1; DONE=1 on cycle 9; READY=1 on cycle 10.
- LOAD=1 with DIN=8'hFF during bit 4 of an 8'h3C transfer -> output still 0,0,1,1,1,1,0,0; 8'hFF is never transmitted.
- LOAD held high with DIN=8'h81 then 8'h7E -> two complete frames, 10-cycle period, SVALID low for exactly 2 cycles between frames.
- CLR asserted after bit 3 of 8'hC3 -> SVALID=0 and READY=1 asynchronously, no DONE; next LOAD with 8'h01 -> 0,0,0,0,0,0,0,1.
- PISO_PARITY_EN defined, DIN=8'h07 -> 0,0,0,0,0,1,1,1 then parity 1; SVALID high 9 cycles. DIN=8'hA5 -> parity bit 0.
